// File: rtl/overture_io_sched.sv
// Core I/O scheduler: one-byte input buffer feeding the core, output FIFO draining core writes.
// Define OVERTURE_IO_TIMEOUT_EN to compile in the stall watchdog that drives err_timeout.
module overture_io_sched #(
    parameter int          UUID      = 0,
    parameter              NAME      = "",
    parameter int          OUT_DEPTH = 4,
    parameter logic [7:0]  TIMEOUT   = 8'd200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       core_in_en,
    output logic [7:0] core_in_value,
    input  logic       core_out_en,
    input  logic [7:0] core_out_value,
    output logic       core_stall,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       err_timeout
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state, state_next;
    logic [7:0]     in_buf;
    logic           load, consume, push, pop;
    logic [7:0]     mem [OUT_DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic [CW-1:0]  count;
    logic           fifo_full, fifo_empty;

    // Full comes from the registered count, so a pop only frees a stalled push next cycle.
    assign fifo_full  = (count == CW'(OUT_DEPTH));
    assign fifo_empty = (count == '0);

    assign core_stall = (core_in_en && state == EMPTY) || (core_out_en && fifo_full);
    assign consume    = core_in_en && !core_stall;
    assign push       = core_out_en && !core_stall;
    assign pop        = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            in_buf <= 8'h00;
        end else begin
            state <= state_next;
            if (load)
                in_buf <= in_data;
        end
    end

    always_comb begin
        state_next    = state;
        load          = 1'b0;
        in_ready      = 1'b0;
        core_in_value = 8'h00;
        case (state)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                core_in_value = in_buf;
                if (consume)
                    state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= core_out_value;
    end

    // Pointers wrap naturally since OUT_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 8'h00 : mem[rptr];

`ifdef OVERTURE_IO_TIMEOUT_EN
    logic [7:0] stall_cnt, stall_cnt_next;

    always_comb begin
        stall_cnt_next = 8'h00;
        if (core_stall)
            stall_cnt_next = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt   <= 8'h00;
            err_timeout <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_next;
            if (stall_cnt_next >= TIMEOUT)
                err_timeout <= 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_overture_io_sched.sv
// Bench for overture_io_sched: vector table with a byte-queue scoreboard on the output FIFO.
module tb_overture_io_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_in_en;
    logic [7:0] core_in_value;
    logic       core_out_en;
    logic [7:0] core_out_value;
    logic       core_stall;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       err_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    overture_io_sched #(.UUID(1), .NAME("tb"), .OUT_DEPTH(4), .TIMEOUT(8'd10)) dut (
        .clk(clk), .rst(rst),
        .core_in_en(core_in_en), .core_in_value(core_in_value),
        .core_out_en(core_out_en), .core_out_value(core_out_value),
        .core_stall(core_stall),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .err_timeout(err_timeout)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] id;
        logic       cie;
        logic       coe;
        logic [7:0] cov;
        logic       ordy;
        logic       e_stall;
        logic [7:0] e_cin;
        logic       e_inrdy;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input logic r, input logic iv, input logic [7:0] id,
                               input logic cie, input logic coe, input logic [7:0] cov,
                               input logic ordy, input logic es, input logic [7:0] ec,
                               input logic er);
        vec_t x;
        x.rst = r; x.iv = iv; x.id = id; x.cie = cie; x.coe = coe; x.cov = cov;
        x.ordy = ordy; x.e_stall = es; x.e_cin = ec; x.e_inrdy = er;
        return x;
    endfunction

    task automatic apply(input vec_t x, input int idx);
        logic       e_ov;
        logic [7:0] e_od;
        rst = x.rst; in_valid = x.iv; in_data = x.id; core_in_en = x.cie;
        core_out_en = x.coe; core_out_value = x.cov; out_ready = x.ordy;
        @(negedge clk);
        e_ov = (sb.size() != 0);
        e_od = e_ov ? sb[0] : 8'h00;
        check($sformatf("v%0d core_stall", idx), {7'd0, core_stall}, {7'd0, x.e_stall});
        check($sformatf("v%0d core_in_value", idx), core_in_value, x.e_cin);
        check($sformatf("v%0d in_ready", idx), {7'd0, in_ready}, {7'd0, x.e_inrdy});
        check($sformatf("v%0d out_valid", idx), {7'd0, out_valid}, {7'd0, e_ov});
        check($sformatf("v%0d out_data", idx), out_data, e_od);
        check($sformatf("v%0d err_timeout", idx), {7'd0, err_timeout}, 8'h00);
        if (x.rst) sb.delete();
        else begin
            if (x.ordy && sb.size() != 0) void'(sb.pop_front());
            if (x.coe && !x.e_stall) sb.push_back(x.cov);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; core_in_en = 1'b0;
        core_out_en = 1'b0; core_out_value = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //          rst iv id     cie coe cov    ordy stall cin    inrdy
        vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1));   // reset state
        // Starved input read stalls, then a byte arrives and is consumed
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 8'h00, 1));
        vecs.push_back(v(0, 1, 8'h5A, 1, 0, 8'h00, 0, 1, 8'h00, 1));
        vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h5A, 0));
        vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1));
        // Fill FIFO, stall on fifth push, release only the cycle after a pop
        for (int i = 1; i <= 4; i++)
            vecs.push_back(v(0, 0, 8'h00, 0, 1, 8'(i), 0, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 8'h00, 0, 1, 8'h05, 0, 1, 8'h00, 1));
        vecs.push_back(v(0, 0, 8'h00, 0, 1, 8'h05, 1, 1, 8'h00, 1));
        vecs.push_back(v(0, 0, 8'h00, 0, 1, 8'h05, 0, 0, 8'h00, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 1));
        // IN->OUT copy blocked by full FIFO stays atomic
        vecs.push_back(v(0, 1, 8'hC3, 0, 1, 8'hA0, 0, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 8'h00, 0, 1, 8'hA1, 0, 0, 8'hC3, 0));
        vecs.push_back(v(0, 0, 8'h00, 0, 1, 8'hA2, 0, 0, 8'hC3, 0));
        vecs.push_back(v(0, 0, 8'h00, 0, 1, 8'hA3, 0, 0, 8'hC3, 0));
        vecs.push_back(v(0, 0, 8'h00, 1, 1, 8'hC3, 0, 1, 8'hC3, 0));
        vecs.push_back(v(0, 0, 8'h00, 1, 1, 8'hC3, 0, 1, 8'hC3, 0));
        vecs.push_back(v(0, 0, 8'h00, 1, 1, 8'hC3, 1, 1, 8'hC3, 0));
        vecs.push_back(v(0, 0, 8'h00, 1, 1, 8'hC3, 0, 0, 8'hC3, 0));
        vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1));
        // Drain to two entries, then simultaneous push/pop
        vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 8'h00, 0, 1, 8'h11, 1, 0, 8'h00, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 1));
        // Reset with three FIFO entries and a held input byte
        vecs.push_back(v(0, 1, 8'h77, 0, 1, 8'h21, 0, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 8'h00, 0, 1, 8'h22, 0, 0, 8'h77, 0));
        vecs.push_back(v(0, 0, 8'h00, 0, 1, 8'h23, 0, 0, 8'h77, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h77, 0));
        vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1));

        foreach (vecs[i]) apply(vecs[i], i);

        // Watchdog: stall for TIMEOUT cycles, flag must stick after stall clears
        core_in_en = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        check("wd before limit", {7'd0, err_timeout}, 8'h00);
        check("wd stall held", {7'd0, core_stall}, 8'h01);
        @(posedge clk); #1;
`ifdef OVERTURE_IO_TIMEOUT_EN
        check("wd at limit", {7'd0, err_timeout}, 8'h01);
`else
        check("wd disabled", {7'd0, err_timeout}, 8'h00);
`endif
        core_in_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`ifdef OVERTURE_IO_TIMEOUT_EN
        check("wd sticky", {7'd0, err_timeout}, 8'h01);
`else
        check("wd disabled idle", {7'd0, err_timeout}, 8'h00);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("wd reset", {7'd0, err_timeout}, 8'h00);
        check("post-reset in_ready", {7'd0, in_ready}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
